xor_result_collector: RTL and testbench
=======================================

XOR_RESULT_COLLECTOR -- requirements
Module: xor_result_collector

Interface
REQ-001 SHALL have parameter W, default 12, meaning the data width, equal to the producing stage's result width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning buffer entries; only powers of two from 2 to 16 are legal.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  result-valid pulse from the upstream XOR stage; there is no backpressure path.
REQ-006 SHALL have port in_data  input  W  result word, sampled only when in_valid=1.
REQ-007 SHALL have port out_valid  output  1  buffer non-empty; the head word is presented.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the head word.
REQ-009 SHALL have port out_data  output  W  head word (first-word-fall-through).
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky flag set when a word is dropped.
REQ-013 SHALL have port drop_cnt  output  8  saturating count of dropped words.
REQ-014 SHALL have port clr  input  1  synchronous clear of overflow, drop_cnt and checksum.

Function
REQ-015 SHALL define push = in_valid & (~full | pop), with pop = out_valid & out_ready.
REQ-016 SHALL write in_data into the tail entry on push and advance the write pointer, wrapping from DEPTH-1 to 0.
REQ-017 SHALL advance the read pointer on pop, wrapping from DEPTH-1 to 0; out_data SHALL then show the next entry in the cycle after the edge.
REQ-018 SHALL keep out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL present a word pushed into an empty buffer with out_valid=1 in the cycle after the push edge (1-cycle latency).
REQ-020 SHALL hold out_valid=0 when empty; out_ready while empty SHALL be ignored and SHALL NOT change count.
REQ-021 SHALL update count as count+1 on push only, count-1 on pop only, and unchanged on push and pop together.
REQ-022 SHALL accept the push when full with a simultaneous pop; count stays DEPTH.
REQ-023 SHALL drop in_data when in_valid=1, full=1 and pop=0, leaving pointers and contents unchanged.
REQ-024 SHALL, on a drop, set overflow=1 and increment drop_cnt, saturating at 255.
REQ-025 SHALL, on clr=1, clear overflow and drop_cnt to 0; when clr and a drop coincide, clr SHALL win and both SHALL read 0 next cycle.
REQ-026 SHALL NOT let clr affect buffer contents, pointers or count.

Reset
REQ-027 SHALL, on rst_n=0, immediately force pointers=0, count=0, out_valid=0, full=0, overflow=0, drop_cnt=0, out_data=0 and checksum=0.
REQ-028 SHALL discard buffered words when reset is asserted mid-operation; the first in_valid after release SHALL be stored at entry 0.
REQ-029 SHALL ignore in_valid and out_ready while rst_n=0.

Configuration
REQ-030 SHALL, when macro COLLECT_CHECKSUM_EN is defined, add output port checksum  output  W  holding the running XOR of every pushed word (dropped words excluded), updated on the push edge and cleared by clr or reset.
REQ-031 SHALL, when COLLECT_CHECKSUM_EN is undefined, have no checksum port and no checksum register, with all other behaviour identical.

Verification
REQ-032 SHALL cover this case: with W=12, DEPTH=4, push 0x00A then 0x0F0 with out_ready=0 -> count=2, out_data=0x00A held; then out_ready=1 -> 0x00A and 0x0F0 come out in order, count=0, out_valid=0.
REQ-033 SHALL cover this case: push 5 words 0x001..0x005 with out_ready=0 -> full=1 after the 4th word, 0x005 dropped, overflow=1, drop_cnt=1, and the drained words are 0x001..0x004.
REQ-034 SHALL cover this case: when full, in_valid and pop occur in the same cycle with in_data=0x123 -> no drop, count stays 4, and 0x123 is the last word drained.
REQ-035 SHALL cover this case: 300 drops -> drop_cnt=255; clr=1 asserted in the same cycle as a drop -> overflow=0 and drop_cnt=0 next cycle.
REQ-036 SHALL cover this case: rst_n pulled low with count=3 -> count=0 and out_valid=0 immediately; after release, push 0x7FF -> out_data=0x7FF.
REQ-037 SHALL cover this case: with COLLECT_CHECKSUM_EN defined, push 0xFFF, 0x0F0, 0x00F -> checksum=0xF00; a dropped word leaves checksum unchanged; clr -> checksum=0.

Source files
------------

// File: rtl/xor_result_collector.sv
//------------------------------------------------------------------------------
// xor_result_collector
//
// Small first-word-fall-through buffer that collects result words from an
// upstream XOR stage. The producer has no backpressure path: when the buffer
// is full and nothing leaves in the same cycle, the incoming word is dropped.
// Each drop sets a sticky overflow flag and bumps a saturating drop counter.
//
// Parameters
//   W      data width (matches the producer's result width)
//   DEPTH  number of entries, power of two in 2..16
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   result-valid pulse from the producer
//   in_data    result word, sampled when in_valid=1
//   out_valid  buffer non-empty, head word presented on out_data
//   out_ready  consumer accepts the head word
//   out_data   head word (zero while the buffer is empty)
//   count      number of occupied entries (0..DEPTH)
//   full       count == DEPTH
//   overflow   sticky: at least one word dropped since reset/clr
//   drop_cnt   saturating (255) count of dropped words
//   clr        synchronous clear of overflow, drop_cnt and checksum
//   checksum   (only with COLLECT_CHECKSUM_EN) running XOR of pushed words
//
// Build option
//   COLLECT_CHECKSUM_EN  when defined, adds the checksum register and port.
//
// Handshake: a word leaves the buffer on every rising edge where
// out_valid=1 and out_ready=1. out_valid never depends on out_ready, and
// while out_valid=1 and out_ready=0 the head word stays put. The input side
// is a plain valid pulse with no ready: a word offered while full is lost
// unless a word leaves in the same cycle.
//------------------------------------------------------------------------------
module xor_result_collector #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr
`ifdef COLLECT_CHECKSUM_EN
  ,
  output logic [W-1:0]             checksum
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Storage and pointers
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Error reporting
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  // Transfer qualifiers
  logic          push;
  logic          pop;
  logic          drop;

  //----------------------------------------------------------------------------
  // Status and transfer decode
  //----------------------------------------------------------------------------
  assign full      = (cnt_q == CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  // A full buffer still takes a word when the head leaves in the same cycle,
  // because the freed slot and the new tail are written on the same edge.
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;

  // Fall-through head; forced to zero when empty so reset shows 0 at once
  // without having to reset the storage array.
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

  //----------------------------------------------------------------------------
  // Next-state logic
  //----------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    // DEPTH is a power of two, so the +1 wraps DEPTH-1 back to 0.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    // clr has priority over a drop in the same cycle.
    if (clr) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  //----------------------------------------------------------------------------
  // State registers
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is not reset: an entry is only visible after a push has written
  // it, and reset empties the buffer through the pointers and count. The
  // write is still qualified with rst_n so nothing is captured while held
  // in reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

`ifdef COLLECT_CHECKSUM_EN
  //----------------------------------------------------------------------------
  // Running XOR of accepted words; dropped words never reach it.
  //----------------------------------------------------------------------------
  logic [W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (clr) begin
      csum_d = '0;
    end else if (push) begin
      csum_d = csum_q ^ in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_xor_result_collector.sv
//------------------------------------------------------------------------------
// tb_xor_result_collector
//
// Bench for xor_result_collector (W=12, DEPTH=4). The driver applies one
// cycle of inputs per call and keeps a queue-level reference model: occupancy
// as an integer, accepted words in exp_q, drop/overflow/checksum as plain
// variables. A separate monitor on the falling edge compares every output
// with the model and pops exp_q on each accepted head word.
//------------------------------------------------------------------------------
module tb_xor_result_collector;

  localparam int W     = 12;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic          in_valid  = 1'b0;
  logic [W-1:0]  in_data   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic [7:0]    drop_cnt;
  logic          clr = 1'b0;
`ifdef COLLECT_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  xor_result_collector #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr       (clr)
`ifdef COLLECT_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // Scoreboard and reference model
  logic [W-1:0] exp_q[$];
  int           m_cnt  = 0;
  bit           m_ovf  = 1'b0;
  int           m_drop = 0;
  logic [W-1:0] m_csum = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. Called at posedge+2; returns at the next posedge+2
  // with the model advanced past that edge.
  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic c);
    bit p, q, dr;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr       = c;
    q  = (m_cnt > 0) && ordy;
    p  = iv && ((m_cnt < DEPTH) || q);
    dr = iv && !p;
    if (p) exp_q.push_back(d);
    @(posedge clk);
    m_cnt = m_cnt + (p ? 1 : 0) - (q ? 1 : 0);
    if (c) begin
      m_ovf  = 1'b0;
      m_drop = 0;
      m_csum = '0;
    end else begin
      if (dr) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (p) m_csum = m_csum ^ d;
    end
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2 && m_cnt > 0; i++) drive(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: compares outputs with the model between edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("count", 32'(count), 32'(m_cnt));
        check("out_valid", {31'd0, out_valid}, {31'd0, (m_cnt != 0)});
        check("full", {31'd0, full}, {31'd0, (m_cnt == DEPTH)});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`ifdef COLLECT_CHECKSUM_EN
        check("checksum", 32'(checksum), 32'(m_csum));
`endif
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            check("out_data", 32'(out_data), 32'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // Reset state while held in reset
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);

    // Two words held, then drained in order
    drive(1'b1, 12'h00A, 1'b0, 1'b0);
    drive(1'b1, 12'h0F0, 1'b0, 1'b0);
    idle(2);
    check("two_count", 32'(count), 32'd2);
    check("two_head", 32'(out_data), 32'h00A);
    drain();

    // Five words into four entries: fifth dropped
    for (int i = 1; i <= 5; i++) drive(1'b1, W'(i), 1'b0, 1'b0);
    check("five_full", {31'd0, full}, 32'd1);
    check("five_overflow", {31'd0, overflow}, 32'd1);
    check("five_drop_cnt", 32'(drop_cnt), 32'd1);
    drain();
    drive(1'b0, '0, 1'b0, 1'b1);

    // Push while full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) drive(1'b1, W'(12'h200 + i), 1'b0, 1'b0);
    drive(1'b1, 12'h123, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 32'(DEPTH));
    check("fullpop_no_drop", {31'd0, overflow}, 32'd0);
    drain();

    // Saturating drop counter, then clr coinciding with a drop
    for (int i = 0; i < DEPTH; i++) drive(1'b1, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) drive(1'b1, W'($urandom), 1'b0, 1'b0);
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    drive(1'b1, 12'h555, 1'b0, 1'b1);
    check("clr_overflow", {31'd0, overflow}, 32'd0);
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
    check("clr_keeps_count", 32'(count), 32'(DEPTH));
    drain();

    // Reset mid-operation with three words buffered
    for (int i = 0; i < 3; i++) drive(1'b1, W'(12'h300 + i), 1'b0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    m_cnt  = 0;
    m_ovf  = 1'b0;
    m_drop = 0;
    m_csum = '0;
    @(posedge clk);
    check("midrst_held", 32'(count), 32'd0);
    #2;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    drive(1'b1, 12'h7FF, 1'b0, 1'b0);
    check("after_rst_data", 32'(out_data), 32'h7FF);
    drain();

`ifdef COLLECT_CHECKSUM_EN
    // Checksum: accepted words only, cleared by clr
    drive(1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 12'hFFF, 1'b0, 1'b0);
    drive(1'b1, 12'h0F0, 1'b0, 1'b0);
    drive(1'b1, 12'h00F, 1'b0, 1'b0);
    check("csum_three", 32'(checksum), 32'hF00);
    drive(1'b1, 12'h111, 1'b0, 1'b0);
    drive(1'b1, 12'hABC, 1'b0, 1'b0);
    check("csum_drop_ignored", 32'(checksum), 32'hE11);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("csum_clr", 32'(checksum), 32'h000);
    drain();
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom),
            ($urandom_range(0, 3) != 0) ? 1'b1 : ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 31) == 0));
    end
    drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
